// File: rtl/prog_sequence_detector.sv
// prog_sequence_detector: runtime-programmable serial bit-pattern detector.
// Matches a loadable pattern of 1..MAX_LEN bits on a 1-bit stream, with
// overlapping or non-overlapping matching, a stall input, a registered
// one-cycle match pulse and a saturating match counter.
module prog_sequence_detector #(
  parameter int unsigned         MAX_LEN       = 8,
  parameter int unsigned         LEN_W         = 4,
  parameter int unsigned         CNT_W         = 8,
  parameter logic [MAX_LEN-1:0]  RESET_PATTERN = MAX_LEN'(5),
  parameter int unsigned         RESET_LEN     = 3,
  parameter bit                  RESET_OVERLAP = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               sequence_in,
  input  logic               load_pattern,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   length_in,
  input  logic               overlap_in,
  input  logic               count_clear,
  output logic               detector_out,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RST_L   = LEN_W'(RESET_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Architectural state
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_det;
  logic [CNT_W-1:0]   r_cnt;

  // Next-state helpers
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic [LEN_W-1:0]   w_len_load;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;
  logic               w_sample;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Shift in the new bit and advance the saturating fill count.
  always_comb begin
    w_hist_next = {r_hist[MAX_LEN-2:0], sequence_in};
    w_fill_next = (r_fill >= MAX_L) ? MAX_L : r_fill + LEN_W'(1);
  end

  // Clamp a requested length into 1..MAX_LEN.
  always_comb begin
    w_len_load = length_in;
    if (length_in == '0) begin
      w_len_load = LEN_W'(1);
    end else if (length_in > MAX_L) begin
      w_len_load = MAX_L;
    end
  end

  // Mask selecting the active low L bits of history and pattern.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      w_mask[i] = (int'(r_len) > i);
    end
  end

  // Match decision for the bit being sampled this cycle.
  always_comb begin
    w_sample  = enable && !load_pattern;
    w_match   = (w_fill_next >= r_len) &&
                ((w_hist_next & w_mask) == (r_pattern & w_mask));
    w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  end

  // Pattern registers, history, fill and match pulse; load beats sampling.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= RESET_PATTERN;
      r_len     <= RST_L;
      r_overlap <= RESET_OVERLAP;
      r_det     <= 1'b0;
    end else if (load_pattern) begin
      r_pattern <= pattern_in;
      r_len     <= w_len_load;
      r_overlap <= overlap_in;
      r_fill    <= '0;
      r_det     <= 1'b0;
    end else if (enable) begin
      r_hist <= w_hist_next;
      r_det  <= w_match;
      // Non-overlap mode restarts collection so L fresh bits are needed.
      r_fill <= (w_match && !r_overlap) ? '0 : w_fill_next;
    end else begin
      r_det <= 1'b0;
    end
  end

  // Saturating match counter; clear wins over a same-edge match.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (count_clear) begin
      r_cnt <= '0;
    end else if (w_sample && w_match) begin
      r_cnt <= w_cnt_inc;
    end
  end

  assign detector_out = r_det;
  assign match_count  = r_cnt;

endmodule

// File: tb/tb_prog_sequence_detector.sv
// Scoreboard bench for prog_sequence_detector: directed vectors push
// expected outputs into queues; a negedge monitor pops and compares.
module tb_prog_sequence_detector;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: default parameters
  logic       a_rst_n, a_en, a_sin, a_ld, a_ovl, a_clr;
  logic [7:0] a_pat;
  logic [3:0] a_len;
  logic       a_det;
  logic [7:0] a_cnt;

  // Instance B: 2-bit counter
  logic       b_rst_n, b_en, b_sin, b_ld, b_ovl, b_clr;
  logic [7:0] b_pat;
  logic [3:0] b_len;
  logic       b_det;
  logic [1:0] b_cnt;

  prog_sequence_detector u_dut_a (
    .clock(clock), .reset(a_rst_n), .enable(a_en), .sequence_in(a_sin),
    .load_pattern(a_ld), .pattern_in(a_pat), .length_in(a_len),
    .overlap_in(a_ovl), .count_clear(a_clr),
    .detector_out(a_det), .match_count(a_cnt)
  );

  prog_sequence_detector #(.CNT_W(2)) u_dut_b (
    .clock(clock), .reset(b_rst_n), .enable(b_en), .sequence_in(b_sin),
    .load_pattern(b_ld), .pattern_in(b_pat), .length_in(b_len),
    .overlap_in(b_ovl), .count_clear(b_clr),
    .detector_out(b_det), .match_count(b_cnt)
  );

  typedef struct packed {
    logic       det;
    logic [7:0] cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: compare DUT outputs produced by the preceding rising edge.
  always @(negedge clock) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      total++;
      if (a_det !== e.det) begin
        bad++;
        $display("FAIL a_det t=%0t got=%b want=%b", $time, a_det, e.det);
      end
      total++;
      if (a_cnt !== e.cnt) begin
        bad++;
        $display("FAIL a_cnt t=%0t got=%0d want=%0d", $time, a_cnt, e.cnt);
      end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      total++;
      if (b_det !== e.det) begin
        bad++;
        $display("FAIL b_det t=%0t got=%b want=%b", $time, b_det, e.det);
      end
      total++;
      if (b_cnt !== e.cnt[1:0]) begin
        bad++;
        $display("FAIL b_cnt t=%0t got=%0d want=%0d", $time, b_cnt, e.cnt[1:0]);
      end
    end
  end

  task automatic a_cyc(input logic rst_n, input logic en, input logic sin,
                       input logic ld, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, input logic clr,
                       input logic exp_det, input logic [7:0] exp_cnt);
    a_rst_n = rst_n; a_en = en; a_sin = sin; a_ld = ld;
    a_pat = pat; a_len = len; a_ovl = ovl; a_clr = clr;
    @(posedge clock);
    qa.push_back({exp_det, exp_cnt});
    #1;
  endtask

  task automatic a_bit(input logic s, input logic d, input logic [7:0] c);
    a_cyc(1'b1, 1'b1, s, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, d, c);
  endtask

  task automatic a_load(input logic [7:0] pat, input logic [3:0] len,
                        input logic ovl, input logic clr, input logic [7:0] c);
    a_cyc(1'b1, 1'b0, 1'b0, 1'b1, pat, len, ovl, clr, 1'b0, c);
  endtask

  task automatic b_cyc(input logic rst_n, input logic en, input logic sin,
                       input logic ld, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, input logic clr,
                       input logic exp_det, input logic [1:0] exp_cnt);
    b_rst_n = rst_n; b_en = en; b_sin = sin; b_ld = ld;
    b_pat = pat; b_len = len; b_ovl = ovl; b_clr = clr;
    @(posedge clock);
    qb.push_back({exp_det, 6'd0, exp_cnt});
    #1;
  endtask

  initial begin
    b_rst_n = 1'b0; b_en = 1'b0; b_sin = 1'b0; b_ld = 1'b0;
    b_pat = 8'h00; b_len = 4'd0; b_ovl = 1'b0; b_clr = 1'b0;

    // Reset
    a_cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 4'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    a_cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Reset defaults 101/L3/overlap on 1,0,1,0,1
    a_bit(1, 0, 0); a_bit(0, 0, 0); a_bit(1, 1, 1); a_bit(0, 0, 1); a_bit(1, 1, 2);

    // Non-overlap 101, load also clears the counter
    a_load(8'b0000_0101, 4'd3, 1'b0, 1'b1, 0);
    a_bit(1, 0, 0); a_bit(0, 0, 0); a_bit(1, 1, 1); a_bit(0, 0, 1);
    a_bit(1, 0, 1); a_bit(0, 0, 1); a_bit(1, 1, 2);

    // 1101 overlap with a 3-cycle stall between bits 5 and 6
    a_load(8'b0000_1101, 4'd4, 1'b1, 1'b1, 0);
    a_bit(1, 0, 0); a_bit(1, 0, 0); a_bit(0, 0, 0); a_bit(1, 1, 1); a_bit(1, 0, 1);
    repeat (3) a_cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 8'd1);
    a_bit(0, 0, 1); a_bit(1, 1, 2);

    // Reset mid-pattern discards progress
    a_bit(1, 0, 2); a_bit(0, 0, 2);
    a_cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    a_bit(1, 0, 0); a_bit(0, 0, 0); a_bit(1, 1, 1);

    // count_clear honoured while stalled
    a_cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0);

    // length_in=0 behaves as L=1
    a_load(8'b0000_0001, 4'd0, 1'b1, 1'b0, 0);
    a_bit(1, 1, 1); a_bit(1, 1, 2); a_bit(0, 0, 2); a_bit(1, 1, 3);

    // length_in=15 behaves as L=8: 00000001 must not match 10000001
    a_load(8'b1000_0001, 4'd15, 1'b1, 1'b0, 3);
    repeat (8) a_bit(0, 0, 3);
    a_bit(1, 0, 3);
    repeat (6) a_bit(0, 0, 3);
    a_bit(1, 1, 4);

    // Load on the edge of a pending final bit: no pulse, fill restarts
    a_load(8'b0000_0101, 4'd3, 1'b1, 1'b0, 4);
    a_bit(1, 0, 4); a_bit(0, 0, 4);
    a_cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0, 8'd4);
    a_bit(1, 0, 4); a_bit(0, 0, 4); a_bit(1, 1, 5);

    a_rst_n = 1'b1; a_en = 1'b0; a_ld = 1'b0; a_clr = 1'b0;

    // Instance B: saturating 2-bit counter with pattern 11
    b_cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    b_cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0, 2'd0);
    b_cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    b_cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 2'd1);
    b_cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 2'd2);
    b_cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 2'd3);
    b_cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 2'd3);
    b_cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 2'd3);
    b_cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 2'd0);
    b_cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 2'd1);
    b_cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1);

    repeat (3) @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
